// File: rtl/wb32_to_wb16_bridge.sv
// rtl/wb32_to_wb16_bridge.sv - Wishbone classic 32-bit to 16-bit width adapter
// Each 32-bit access becomes up to two big-endian 16-bit accesses: high half at A, low half at A+2.
module wb32_to_wb16_bridge #(
   parameter int TIMEOUT = 16,
   parameter int TO_W    = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic [31:0] wbs_dat_o,
   input  logic [3:0]  wbs_sel_i,
   input  logic        wbs_we_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   output logic        wbs_ack_o,
   output logic        wbs_err_o,
   output logic [31:0] wbm_adr_o,
   output logic [15:0] wbm_dat_o,
   input  logic [15:0] wbm_dat_i,
   output logic [1:0]  wbm_sel_o,
   output logic        wbm_we_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   input  logic        wbm_ack_i
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HI   = 3'd1,
      GAP  = 3'd2,
      LO   = 3'd3,
      RESP = 3'd4
   } state_t;

   state_t state, state_nx;

   logic [29:0]     adr_q;
   logic [31:0]     dat_q;
   logic [31:0]     rd_q;
   logic [3:0]      sel_q;
   logic            we_q;
   logic            err_q;
   logic [TO_W-1:0] wd_q;
   logic            req;
   logic            timeout_hit;
   logic            adr_unused;

   assign req         = wbs_cyc_i & wbs_stb_i;
   assign timeout_hit = (TIMEOUT != 0) && (wd_q == TO_W'(TIMEOUT));
   assign adr_unused  = ^wbs_adr_i[1:0];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
         adr_q <= '0;
         dat_q <= '0;
         rd_q  <= '0;
         sel_q <= '0;
         we_q  <= 1'b0;
         err_q <= 1'b0;
         wd_q  <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               wd_q <= '0;
               if (req) begin
                  adr_q <= wbs_adr_i[31:2];
                  dat_q <= wbs_dat_i;
                  sel_q <= wbs_sel_i;
                  we_q  <= wbs_we_i;
                  rd_q  <= '0;
                  err_q <= 1'b0;
               end
            end
            HI, LO: begin
               // an ack arriving on the timeout cycle still completes the half
               if (wbm_ack_i) begin
                  if (state == HI) rd_q[31:16] <= wbm_dat_i;
                  else             rd_q[15:0]  <= wbm_dat_i;
               end else if (timeout_hit) begin
                  err_q <= 1'b1;
               end else begin
                  wd_q <= wd_q + TO_W'(1);
               end
            end
            default: wd_q <= '0;
         endcase
      end
   end

   always_comb begin
      state_nx  = state;
      wbs_ack_o = 1'b0;
      wbs_err_o = 1'b0;
      wbs_dat_o = '0;
      wbm_adr_o = {adr_q, (state == LO), 1'b0};
      wbm_dat_o = '0;
      wbm_sel_o = '0;
      wbm_we_o  = 1'b0;
      wbm_cyc_o = 1'b0;
      wbm_stb_o = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (|wbs_sel_i[3:2])      state_nx = HI;
               else if (|wbs_sel_i[1:0]) state_nx = LO;
               else                      state_nx = RESP;
            end
         end
         HI: begin
            wbm_cyc_o = 1'b1;
            wbm_stb_o = 1'b1;
            wbm_we_o  = we_q;
            wbm_sel_o = sel_q[3:2];
            wbm_dat_o = dat_q[31:16];
            if (!wbs_cyc_i)       state_nx = IDLE;
            else if (wbm_ack_i)   state_nx = (|sel_q[1:0]) ? GAP : RESP;
            else if (timeout_hit) state_nx = RESP;
         end
         GAP: begin
            // lets a registered-ack slave drop its trailing ack before the low half
            if (!wbs_cyc_i) state_nx = IDLE;
            else            state_nx = LO;
         end
         LO: begin
            wbm_cyc_o = 1'b1;
            wbm_stb_o = 1'b1;
            wbm_we_o  = we_q;
            wbm_sel_o = sel_q[1:0];
            wbm_dat_o = dat_q[15:0];
            if (!wbs_cyc_i)                   state_nx = IDLE;
            else if (wbm_ack_i | timeout_hit) state_nx = RESP;
         end
         RESP: begin
            wbs_ack_o = ~err_q;
            wbs_err_o = err_q;
            wbs_dat_o = rd_q;
            state_nx  = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_wb32_to_wb16_bridge.sv
// tb/tb_wb32_to_wb16_bridge.sv - randomized self-checking bench for wb32_to_wb16_bridge
// Drives on negedge, samples on negedge; slave is a 16-bit memory with programmable ack delay.
module tb_wb32_to_wb16_bridge;
   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
   logic [3:0]  wbs_sel_i;
   logic        wbs_we_i, wbs_cyc_i, wbs_stb_i, wbs_ack_o, wbs_err_o;
   logic [31:0] wbm_adr_o;
   logic [15:0] wbm_dat_o, wbm_dat_i;
   logic [1:0]  wbm_sel_o;
   logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i;

   always #5 clk = ~clk;

   wb32_to_wb16_bridge #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
      .clk_i(clk), .rst_i(rst),
      .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_dat_o(wbs_dat_o),
      .wbs_sel_i(wbs_sel_i), .wbs_we_i(wbs_we_i), .wbs_cyc_i(wbs_cyc_i),
      .wbs_stb_i(wbs_stb_i), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
      .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
      .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o),
      .wbm_stb_o(wbm_stb_o), .wbm_ack_i(wbm_ack_i)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] seed_word(input int i);
      return 16'(i * 32'h1357) ^ 16'h5a5a;
   endfunction

   // downstream slave: ack registered from stb&cyc after sl_delay extra cycles
   logic [15:0] sl_mem [256];
   logic [15:0] ref_mem [256];
   logic        init_mem = 1'b1;
   int          sl_delay = 0;
   bit          sl_never = 1'b0;
   int          sl_cnt = 0;
   logic        sl_ack = 1'b0;
   logic [31:0] acc_q [$];
   int          lo_issued = 0;
   int          we_viol = 0;
   int          resp_viol = 0;
   logic        prev_resp = 1'b0;

   assign wbm_ack_i = sl_ack;
   assign wbm_dat_i = sl_mem[wbm_adr_o[8:1]];

   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < 256; i++) sl_mem[i] <= seed_word(i);
      end
      if (wbm_cyc_o && wbm_stb_o) begin
         sl_ack <= !sl_never && (sl_cnt >= sl_delay);
         sl_cnt <= sl_cnt + 1;
         if (wbm_adr_o[1]) lo_issued <= lo_issued + 1;
      end else begin
         sl_ack <= 1'b0;
         sl_cnt <= 0;
      end
      if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
         acc_q.push_back(wbm_adr_o);
         if (wbm_we_o) begin
            if (wbm_sel_o[1]) sl_mem[wbm_adr_o[8:1]][15:8] <= wbm_dat_o[15:8];
            if (wbm_sel_o[0]) sl_mem[wbm_adr_o[8:1]][7:0]  <= wbm_dat_o[7:0];
         end
      end
      if (wbm_we_o && !wbm_stb_o) we_viol <= we_viol + 1;
   end

   always @(negedge clk) begin
      if ((wbs_ack_o && wbs_err_o) || ((wbs_ack_o || wbs_err_o) && prev_resp))
         resp_viol <= resp_viol + 1;
      prev_resp <= wbs_ack_o || wbs_err_o;
   end

   // one upstream access, called just after a negedge in IDLE; model derived from the bridge rules
   task automatic xact(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input bit w, input int dly, input bit never, input string tag,
                       output int lat, output logic [31:0] rd);
      bit          hi, lo, to, exp_err, got_ack, got_err;
      int          hi_i, lo_i, exp_lat, n;
      logic [31:0] exp_rd;
      logic [31:0] exp_adr [$];
      hi   = |s[3:2];
      lo   = |s[1:0];
      hi_i = int'(a[8:2]) * 2;
      lo_i = hi_i + 1;
      to   = never || (dly + 1 > TIMEOUT);
      if (!hi && !lo) begin
         exp_lat = 1; exp_err = 0;
      end else if (to) begin
         exp_lat = TIMEOUT + 2; exp_err = 1;
      end else begin
         exp_lat = 1 + (hi ? dly + 2 : 0) + ((hi && lo) ? 1 : 0) + (lo ? dly + 2 : 0);
         exp_err = 0;
      end
      exp_rd = '0;
      if (!exp_err && !w) begin
         if (hi) exp_rd[31:16] = ref_mem[hi_i];
         if (lo) exp_rd[15:0]  = ref_mem[lo_i];
      end
      if (!exp_err) begin
         if (hi) exp_adr.push_back({a[31:2], 2'b00});
         if (lo) exp_adr.push_back({a[31:2], 2'b10});
      end
      sl_delay = dly;
      sl_never = never;
      acc_q.delete();
      wbs_adr_i = a; wbs_dat_i = d; wbs_sel_i = s; wbs_we_i = w;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
      n = 0; got_ack = 0; got_err = 0; rd = '0;
      while (n < 200 && !got_ack && !got_err) begin
         @(negedge clk);
         n++;
         got_ack = wbs_ack_o;
         got_err = wbs_err_o;
         rd      = wbs_dat_o;
      end
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      lat = n;
      check({tag, "_lat"}, n, exp_lat);
      check({tag, "_resp"}, {30'd0, got_ack, got_err}, {30'd0, !exp_err, exp_err});
      if (!w || exp_err) check({tag, "_rd"}, rd, exp_rd);
      check({tag, "_nacc"}, acc_q.size(), exp_adr.size());
      for (int i = 0; i < exp_adr.size() && i < acc_q.size(); i++)
         check({tag, "_adr"}, acc_q[i], exp_adr[i]);
      if (w && !exp_err) begin
         if (s[3]) ref_mem[hi_i][15:8] = d[31:24];
         if (s[2]) ref_mem[hi_i][7:0]  = d[23:16];
         if (s[1]) ref_mem[lo_i][15:8] = d[15:8];
         if (s[0]) ref_mem[lo_i][7:0]  = d[7:0];
      end
      @(negedge clk);
   endtask

   initial begin
      int          lat, lo0, mm;
      logic [31:0] rd;
      bit          saw;
      for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);
      rst = 1'b1;
      wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = '0; wbs_we_i = 1'b0;
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      repeat (3) @(negedge clk);
      init_mem = 1'b0;
      check("reset_outs", {31'd0, |{wbs_ack_o, wbs_err_o, wbs_dat_o, wbm_adr_o, wbm_dat_o,
                                    wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o}}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      xact(32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 0, 1'b0, "t1w", lat, rd);
      check("t1w_lat6", lat, 6);
      check("t1_mem_hi", {16'd0, sl_mem[8]}, 32'h0000DEAD);
      check("t1_mem_lo", {16'd0, sl_mem[9]}, 32'h0000BEEF);
      xact(32'h10, 32'h0, 4'hF, 1'b0, 0, 1'b0, "t1r", lat, rd);
      check("t1r_data", rd, 32'hDEADBEEF);
      check("t1r_lat6", lat, 6);

      xact(32'h20, 32'h0, 4'hC, 1'b0, 0, 1'b0, "t2c", lat, rd);
      check("t2c_lat3", lat, 3);
      check("t2c_lo0", {16'd0, rd[15:0]}, 32'd0);
      xact(32'h20, 32'h0, 4'h3, 1'b0, 0, 1'b0, "t2s", lat, rd);
      check("t2s_lat3", lat, 3);

      xact(32'h30, 32'h0, 4'h0, 1'b0, 0, 1'b0, "t3", lat, rd);
      check("t3_lat1", lat, 1);
      check("t3_rd0", rd, 32'd0);

      lo0 = lo_issued;
      xact(32'h40, 32'h0, 4'hF, 1'b0, 0, 1'b1, "t4", lat, rd);
      check("t4_lat18", lat, 18);
      check("t4_no_lo", lo_issued - lo0, 0);
      xact(32'h44, 32'h0, 4'hC, 1'b0, 15, 1'b0, "edge15", lat, rd);
      xact(32'h44, 32'h0, 4'h3, 1'b0, 16, 1'b0, "edge16", lat, rd);

      // abort in the gap cycle (cycle 3 with a 1-cycle-ack slave)
      sl_delay = 0; sl_never = 1'b0; acc_q.delete();
      wbs_adr_i = 32'h80; wbs_dat_i = 32'h12345678; wbs_sel_i = 4'hF; wbs_we_i = 1'b1;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
      repeat (3) @(negedge clk);
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      saw = (wbs_ack_o || wbs_err_o);
      @(negedge clk);
      check("t5_drop", {29'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 32'd0);
      repeat (6) begin
         saw |= (wbs_ack_o || wbs_err_o);
         @(negedge clk);
      end
      check("t5_noresp", {31'd0, saw}, 32'd0);
      check("t5_nacc", acc_q.size(), 1);
      check("t5_hi", {16'd0, sl_mem[64]}, 32'h00001234);
      check("t5_lo", {16'd0, sl_mem[65]}, {16'd0, ref_mem[65]});
      ref_mem[64] = 16'h1234;
      xact(32'h80, 32'h0, 4'hF, 1'b0, 0, 1'b0, "t5r", lat, rd);

      // reset during the low half (cycle 4)
      acc_q.delete();
      wbs_adr_i = 32'h60; wbs_sel_i = 4'hF; wbs_we_i = 1'b0;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("t6_outs", {31'd0, |{wbs_ack_o, wbs_err_o, wbs_dat_o, wbm_cyc_o, wbm_stb_o,
                                 wbm_we_o, wbm_sel_o, wbm_dat_o}}, 32'd0);
      rst = 1'b0;
      xact(32'h64, 32'h0, 4'hF, 1'b0, 0, 1'b0, "t6b2b", lat, rd);
      check("t6_lat6", lat, 6);

      for (int k = 0; k < 60; k++) begin
         xact($urandom, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), 1'b0, "rnd", lat, rd);
      end

      mm = 0;
      for (int i = 0; i < 256; i++) if (sl_mem[i] !== ref_mem[i]) mm++;
      check("mem_image", mm, 0);
      check("we_outside_stb", we_viol, 0);
      check("resp_pulse", resp_viol, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
